// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the staged pipeline: default geometry, the STEP_MODE
// encodings and a width helper usable in port and parameter declarations.
package pipeline_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_STAGES = 4;

    // STEP_MODE encodings
    localparam int STEP_FREE = 0;   // advance every cycle
    localparam int STEP_EDGE = 1;   // advance only on a rising edge of step

    // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/step_edge_detect.sv
// step_edge_detect
// Rising-edge detector for the step level input.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   in    : level input
//   pulse : one-cycle high when in is 1 and was 0 on the previous cycle
// The history register resets to 1 so that an input already high when reset
// is released is not mistaken for a fresh rising edge.
module step_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
// Linear chain of STAGES payload registers with per-stage stall and flush.
// Stage 0 is the youngest (input side), stage STAGES-1 the oldest (output).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   step         : level input; its rising edge is the tick when STEP_MODE=1
//   in_valid/in_data/in_ready : input side; in_ready is combinational
//   stall_req[k] : stage k (and everything younger) holds on a tick
//   flush_req[k] : stages 0..k are killed on a tick (beats stall)
//   stage_valid/stage_data    : per-stage state, stage k at [k*DATA_W +: DATA_W]
//   out_valid/out_data        : oldest stage
//   advance      : the internal tick is active this cycle
//   occupancy    : number of valid stages, registered alongside valid
module pipe_stage_chain
    import pipeline_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int STAGES    = DEFAULT_STAGES,
    parameter int STEP_MODE = STEP_FREE
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             step,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    input  logic [STAGES-1:0]                stall_req,
    input  logic [STAGES-1:0]                flush_req,
    output logic [STAGES-1:0]                stage_valid,
    output logic [STAGES*DATA_W-1:0]         stage_data,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                out_data,
    output logic                             advance,
    output logic [clog2(STAGES+1)-1:0]       occupancy
);

    localparam int OCC_W = clog2(STAGES + 1);

    logic                           step_pulse;
    logic                           tick;
    logic [STAGES-1:0]              hold;
    logic [STAGES-1:0]              kill;
    logic [STAGES-1:0]              valid_q;
    logic [STAGES-1:0]              valid_d;
    logic [STAGES-1:0]              load;
    logic [STAGES-1:0][DATA_W-1:0]  data_q;
    logic [OCC_W-1:0]               occ_q;
    logic [OCC_W-1:0]               occ_d;

    step_edge_detect u_step_edge (
        .clock (clock),
        .reset (reset),
        .in    (step),
        .pulse (step_pulse)
    );

    assign tick    = (STEP_MODE == STEP_EDGE) ? step_pulse : 1'b1;
    assign advance = tick;

    // A stall anywhere downstream freezes everything upstream of it; a flush
    // anywhere downstream kills everything upstream of it.
    always_comb begin
        hold = '0;
        kill = '0;
        hold[STAGES-1] = stall_req[STAGES-1];
        kill[STAGES-1] = flush_req[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            hold[k] = hold[k+1] | stall_req[k];
            kill[k] = kill[k+1] | flush_req[k];
        end
    end

    // Stall is applied to the input port even between ticks.
    assign in_ready = ~hold[0];

    // Next-state of valid and data-load enables, assuming a tick.
    // A stage whose predecessor is held receives a bubble; data registers
    // only move on a valid load so bubbles and kills leave stale data behind.
    always_comb begin
        valid_d = valid_q;
        load    = '0;

        if (kill[0]) begin
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            valid_d[0] = in_valid;
            load[0]    = in_valid;
        end

        for (int k = 1; k < STAGES; k++) begin
            if (kill[k]) begin
                valid_d[k] = 1'b0;
            end else if (!hold[k]) begin
                valid_d[k] = valid_q[k-1] & ~hold[k-1];
                load[k]    = valid_q[k-1] & ~hold[k-1];
            end
        end
    end

    // Occupancy is registered from the same next-valid vector so it tracks
    // stage_valid cycle for cycle without a popcount on the output path.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
            occ_q   <= '0;
        end else if (tick) begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            if (load[0]) begin
                data_q[0] <= in_data;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign occupancy   = occ_q;

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width per stage.
REQ-002 SHALL have parameter STAGES, default 4, legal 2..8, pipeline depth; index 0 is youngest (input side), STAGES-1 oldest (output side).
REQ-003 SHALL have parameter STEP_MODE, default 0; 0 = advance every cycle, 1 = advance only on a rising edge of step.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 step  in  1  level input, edge-detected internally; ignored when STEP_MODE=0.
REQ-008 in_valid  in  1  input payload present.
REQ-009 in_data  in  DATA_W  input payload.
REQ-010 in_ready  out  1  stage 0 can accept.
REQ-011 stall_req  in  STAGES  bit k: stage k must hold.
REQ-012 flush_req  in  STAGES  bit k: kill stages 0..k.
REQ-013 stage_valid  out  STAGES  per-stage valid.
REQ-014 stage_data  out  STAGES*DATA_W  per-stage payload, stage k at bits [k*DATA_W +: DATA_W].
REQ-015 out_valid / out_data  out  1 / DATA_W  stage STAGES-1 valid and payload.
REQ-016 advance  out  1  internal tick is active this cycle.
REQ-017 occupancy  out  clog2(STAGES+1)  count of valid stages.

Function
REQ-018 tick SHALL be 1 every cycle when STEP_MODE=0, else step & ~step_q, where step_q is step registered one cycle; advance = tick.
REQ-019 Without tick, all valid, data and occupancy registers SHALL hold regardless of stall_req/flush_req.
REQ-020 hold[k] = OR of stall_req[j] for j>=k; stall at stage k SHALL also hold all younger stages.
REQ-021 kill[k] = OR of flush_req[j] for j>=k.
REQ-022 in_ready = ~hold[0], combinational, independent of tick.
REQ-023 On tick, kill[k] SHALL clear valid[k]; kill takes priority over hold.
REQ-024 Otherwise, on tick, hold[k] SHALL keep stage k unchanged.
REQ-025 Otherwise, on tick, stage k>0 SHALL load valid/data from stage k-1, with valid forced 0 (bubble) when hold[k-1].
REQ-026 Otherwise, on tick, stage 0 SHALL load in_valid/in_data; input is consumed when tick & in_valid & in_ready, including when kill[0] discards it.
REQ-027 Data registers SHALL change only on a valid load; on bubble or kill, data keeps its previous value.
REQ-028 The output transfer completes on tick & out_valid & ~stall_req[STAGES-1]; there is no other output handshake.
REQ-029 occupancy SHALL equal popcount(stage_valid) and update in the same cycle as valid.
REQ-030 Latency, with no stall or flush, SHALL be STAGES ticks from input accept to out_valid.

Reset
REQ-031 On reset: all stage_valid=0, occupancy=0, all data registers=0, and step_q=1, so a step held high across reset release produces no tick.
REQ-032 Reset SHALL override tick, stall and flush in the same cycle; in_ready=1 after reset when stall_req=0.

Structure
REQ-033 A shared package pipeline_pkg SHALL hold the clog2 function, DATA_W/STAGES defaults and the STEP_MODE encodings.
REQ-034 Rising-edge detection SHALL be a sub-module step_edge_detect (clock, reset, in, pulse); all other logic is flat.

Verification
REQ-035 Config DATA_W=32, STAGES=4, STEP_MODE=0 unless stated.
REQ-036 Fill: feed 0x11, 0x22, 0x33, 0x44 on consecutive cycles, no stall -> out_valid=1 with 0x11 on the 4th edge after first accept; occupancy=4.
REQ-037 Mid stall: full pipe s3..s0 = 0x11, 0x22, 0x33, 0x44; stall_req=4'b0010 for one tick -> s3=0x22, s2 bubble, s1=0x33, s0=0x44, in_ready=0, occupancy=3.
REQ-038 Flush: full pipe, flush_req=4'b0100, in_valid=1 with 0x55 -> s0..s2 invalid, s3=0x22, 0x55 consumed and discarded, occupancy=1; flush_req=4'b0010 together with stall_req=4'b0010 -> s0 and s1 invalid.
REQ-039 Step mode: STEP_MODE=1, step high for 10 cycles -> exactly one advance; 3 low/high pulses -> 3 advances; step high through reset release -> zero advances.
REQ-040 Reset mid-run: full pipe, reset asserted for 1 cycle -> stage_valid=0, occupancy=0, in_ready=1 on the next cycle.
